// File: rtl/ber_checker.sv
// ber_checker: receive-end bit-error-rate monitor.
// Keeps a history of the bits fed to the encoder and searches for the
// decoder latency. Once it finds that latency it locks and counts decoded
// bits and mismatches. It drops lock and searches again when one block of
// samples holds too many errors.
module ber_checker #(
    parameter int MAX_LAT      = 64,
    parameter int SYNC_WIN     = 32,
    parameter int SYNC_ERR_MAX = 2,
    parameter int LOSS_WIN     = 64,
    parameter int LOSS_ERR     = 16,
    parameter int CNT_W        = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ref_bit_i,
    input  logic                       ref_valid_i,
    input  logic                       dec_bit_i,
    input  logic                       dec_valid_i,
    input  logic                       clear_i,
    output logic                       locked_o,
    output logic [$clog2(MAX_LAT)-1:0] lat_o,
    output logic [CNT_W-1:0]           bit_cnt_o,
    output logic [CNT_W-1:0]           err_cnt_o,
    output logic [7:0]                 resync_cnt_o,
    output logic                       err_pulse_o
);

    localparam int LAT_W  = $clog2(MAX_LAT);
    localparam int WIN_W  = $clog2(SYNC_WIN + 1);
    localparam int WERR_W = $clog2(SYNC_ERR_MAX + 2);
    localparam int BLK_W  = $clog2(LOSS_WIN + 1);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [MAX_LAT-1:0] hist;
    logic [LAT_W-1:0]   lat;
    logic [WIN_W-1:0]   win_cnt;
    logic [WERR_W-1:0]  win_err;
    logic [BLK_W-1:0]   blk_cnt;
    logic [BLK_W-1:0]   blk_err;
    logic [CNT_W-1:0]   bit_cnt;
    logic [CNT_W-1:0]   err_cnt;
    logic [7:0]         resync_cnt;
    logic               err_pulse;

    logic               mis;
    logic [WIN_W-1:0]   win_cnt_inc;
    logic [WERR_W-1:0]  win_err_inc;
    logic [BLK_W-1:0]   blk_cnt_inc;
    logic [BLK_W-1:0]   blk_err_inc;
    logic               win_done;
    logic               win_pass;
    logic               blk_done;
    logic               blk_fail;

    // Compare the decoded bit against the pre-shift history and decide window/block outcomes
    always_comb begin
        mis         = dec_bit_i ^ hist[lat];
        win_cnt_inc = win_cnt + WIN_W'(1);
        win_err_inc = (win_err == WERR_W'(SYNC_ERR_MAX + 1)) ? win_err
                                                             : win_err + WERR_W'(mis);
        blk_cnt_inc = blk_cnt + BLK_W'(1);
        blk_err_inc = blk_err + BLK_W'(mis);
        win_done    = 1'b0;
        win_pass    = 1'b0;
        blk_done    = 1'b0;
        blk_fail    = 1'b0;
        state_next  = state;
        if (clear_i) begin
            state_next = SEARCH;
        end else if (dec_valid_i) begin
            case (state)
                SEARCH: begin
                    if (win_cnt_inc == WIN_W'(SYNC_WIN)) begin
                        win_done = 1'b1;
                        if (win_err_inc <= WERR_W'(SYNC_ERR_MAX)) begin
                            win_pass   = 1'b1;
                            state_next = LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    if (blk_cnt_inc == BLK_W'(LOSS_WIN)) begin
                        blk_done = 1'b1;
                        if (blk_err_inc > BLK_W'(LOSS_ERR)) begin
                            blk_fail   = 1'b1;
                            state_next = SEARCH;
                        end
                    end
                end
                default: state_next = SEARCH;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= SEARCH;
        end else begin
            state <= state_next;
        end
    end

    // Reference history: hist[0] is the newest accepted bit; clear leaves it intact
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist <= '0;
        end else if (ref_valid_i) begin
            hist <= {hist[MAX_LAT-2:0], ref_bit_i};
        end
    end

    // Candidate latency and per-candidate search window
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat     <= '0;
            win_cnt <= '0;
            win_err <= '0;
        end else if (clear_i) begin
            lat     <= '0;
            win_cnt <= '0;
            win_err <= '0;
        end else if (state == LOCKED) begin
            if (blk_fail) begin
                lat <= '0;
            end
        end else if (dec_valid_i) begin
            if (win_done) begin
                win_cnt <= '0;
                win_err <= '0;
                if (!win_pass) begin
                    lat <= lat + LAT_W'(1);
                end
            end else begin
                win_cnt <= win_cnt_inc;
                win_err <= win_err_inc;
            end
        end
    end

    // Locked statistics, loss-of-lock blocks and the registered error pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt    <= '0;
            err_cnt    <= '0;
            resync_cnt <= '0;
            blk_cnt    <= '0;
            blk_err    <= '0;
            err_pulse  <= 1'b0;
        end else if (clear_i) begin
            bit_cnt    <= '0;
            err_cnt    <= '0;
            resync_cnt <= '0;
            blk_cnt    <= '0;
            blk_err    <= '0;
            err_pulse  <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            if (state == LOCKED && dec_valid_i) begin
                err_pulse <= mis;
                if (bit_cnt != '1) begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
                if (mis && err_cnt != '1) begin
                    err_cnt <= err_cnt + CNT_W'(1);
                end
                if (blk_done) begin
                    blk_cnt <= '0;
                    blk_err <= '0;
                    if (blk_fail && resync_cnt != 8'hFF) begin
                        resync_cnt <= resync_cnt + 8'd1;
                    end
                end else begin
                    blk_cnt <= blk_cnt_inc;
                    blk_err <= blk_err_inc;
                end
            end
        end
    end

    assign locked_o     = (state == LOCKED);
    assign lat_o        = lat;
    assign bit_cnt_o    = bit_cnt;
    assign err_cnt_o    = err_cnt;
    assign resync_cnt_o = resync_cnt;
    assign err_pulse_o  = err_pulse;

endmodule

// File: tb/tb_ber_checker.sv
// tb_ber_checker: directed bench for ber_checker.
// The reference is a PRBS-7 stream. The decoded stream is that reference
// delayed six ref events (latency 5), with optional bit inversions.
module tb_ber_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        ref_bit_i;
    logic        ref_valid_i;
    logic        dec_bit_i;
    logic        dec_valid_i;
    logic        clear_i;
    logic        locked_o;
    logic [5:0]  lat_o;
    logic [15:0] bit_cnt_o;
    logic [15:0] err_cnt_o;
    logic [7:0]  resync_cnt_o;
    logic        err_pulse_o;

    ber_checker dut (
        .clk          (clk),
        .rst          (rst),
        .ref_bit_i    (ref_bit_i),
        .ref_valid_i  (ref_valid_i),
        .dec_bit_i    (dec_bit_i),
        .dec_valid_i  (dec_valid_i),
        .clear_i      (clear_i),
        .locked_o     (locked_o),
        .lat_o        (lat_o),
        .bit_cnt_o    (bit_cnt_o),
        .err_cnt_o    (err_cnt_o),
        .resync_cnt_o (resync_cnt_o),
        .err_pulse_o  (err_pulse_o)
    );

    // Free-running clock
    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    n;
        int    inv_period;
        bit    invert_all;
        bit    gated;
        bit    clear_first;
        int    exp_locked;
        int    exp_lat;
        int    exp_bit;
        int    exp_err;
        int    exp_resync;
        int    exp_pulses;
        int    exp_seen;
    } vec_t;

    vec_t     vecs [5];
    int       vectors_applied = 0;
    int       miscompares     = 0;
    logic [6:0] prbs          = 7'h7F;
    bit       ref_log [0:16383];
    int       ref_cnt         = 0;
    int       cyc             = 0;
    int       pulse_cnt       = 0;
    bit       seen_lock       = 1'b0;
    bit       fired;

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors_applied++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // One clock of stimulus. The decoded bit is the reference accepted six ref events earlier.
    task automatic applyStimulus(input bit gated, input bit dec_en, input bit flip,
                                 input bit do_clear, output bit dec_fired);
        bit rv;
        bit dv;
        bit nb;
        int phase;
        phase       = cyc % 4;
        rv          = gated ? (phase < 2) : 1'b1;
        dv          = dec_en && (gated ? (phase == 1 || phase == 2) : 1'b1);
        dec_valid_i = dv;
        dec_bit_i   = dv ? (ref_log[ref_cnt - 6] ^ flip) : 1'b0;
        ref_valid_i = rv;
        ref_bit_i   = 1'b0;
        if (rv) begin
            nb             = prbs[6] ^ prbs[5];
            prbs           = {prbs[5:0], nb};
            ref_bit_i      = nb;
            ref_log[ref_cnt] = nb;
            ref_cnt++;
        end
        clear_i = do_clear;
        @(posedge clk);
        #1;
        cyc++;
        dec_fired = dv;
        if (err_pulse_o) pulse_cnt++;
        if (locked_o) seen_lock = 1'b1;
    endtask

    task automatic runSamples(input int n, input int inv_period, input int inv_first,
                              input bit invert_all, input bit gated);
        int s;
        bit f;
        bit flip;
        s = 0;
        for (int c = 0; c < 4 * n + 8 && s < n; c++) begin
            flip = invert_all || (inv_period > 0 && (s % inv_period) == inv_period - 1)
                   || (s < inv_first);
            applyStimulus(gated, 1'b1, flip, 1'b0, f);
            if (f) s++;
        end
    endtask

    task automatic checkAll(input string tag, input int lk, input int lt, input int bc,
                            input int ec, input int rc, input int ep);
        checkOutput({tag, ".locked"}, int'(locked_o), lk);
        checkOutput({tag, ".lat"}, int'(lat_o), lt);
        checkOutput({tag, ".bit_cnt"}, int'(bit_cnt_o), bc);
        checkOutput({tag, ".err_cnt"}, int'(err_cnt_o), ec);
        checkOutput({tag, ".resync"}, int'(resync_cnt_o), rc);
        checkOutput({tag, ".err_pulse"}, int'(err_pulse_o), ep);
    endtask

    // Absolute time limit so the run always terminates
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence
    initial begin
        vecs[0] = '{"every8th", 256, 8, 1'b0, 1'b0, 1'b0, 1, 5, 256, 32, 0, 32, 1};
        vecs[1] = '{"every2nd",  64, 2, 1'b0, 1'b0, 1'b0, 0, 0, 320, 64, 1, 32, 1};
        vecs[2] = '{"relock",   192, 0, 1'b0, 1'b0, 1'b0, 1, 5, 320, 64, 1,  0, 1};
        vecs[3] = '{"uncorr",  6144, 0, 1'b1, 1'b0, 1'b1, 0, 0,   0,  0, 0,  0, 0};
        vecs[4] = '{"gated",    256, 0, 1'b0, 1'b1, 1'b1, 1, 5,  64,  0, 0,  0, 1};

        rst         = 1'b0;
        ref_bit_i   = 1'b0;
        ref_valid_i = 1'b0;
        dec_bit_i   = 1'b0;
        dec_valid_i = 1'b0;
        clear_i     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkAll("reset", 0, 0, 0, 0, 0, 0);
        #2 rst = 1'b1;

        for (int i = 0; i < 70; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, fired);

        // Search steps one latency per 32 samples, then locks at 5
        for (int j = 1; j <= 5; j++) begin
            runSamples(32, 0, 0, 1'b0, 1'b0);
            checkOutput($sformatf("search%0d.lat", j), int'(lat_o), j);
            checkOutput($sformatf("search%0d.locked", j), int'(locked_o), 0);
        end
        runSamples(31, 0, 0, 1'b0, 1'b0);
        checkOutput("s191.locked", int'(locked_o), 0);
        checkOutput("s191.lat", int'(lat_o), 5);
        runSamples(1, 0, 0, 1'b0, 1'b0);
        checkAll("s192", 1, 5, 0, 0, 0, 0);

        for (int i = 0; i < 5; i++) begin
            if (vecs[i].clear_first) applyStimulus(vecs[i].gated, 1'b1, 1'b0, 1'b1, fired);
            pulse_cnt = 0;
            seen_lock = 1'b0;
            runSamples(vecs[i].n, vecs[i].inv_period, 0, vecs[i].invert_all, vecs[i].gated);
            checkOutput({vecs[i].name, ".locked"}, int'(locked_o), vecs[i].exp_locked);
            checkOutput({vecs[i].name, ".lat"}, int'(lat_o), vecs[i].exp_lat);
            checkOutput({vecs[i].name, ".bit_cnt"}, int'(bit_cnt_o), vecs[i].exp_bit);
            checkOutput({vecs[i].name, ".err_cnt"}, int'(err_cnt_o), vecs[i].exp_err);
            checkOutput({vecs[i].name, ".resync"}, int'(resync_cnt_o), vecs[i].exp_resync);
            checkOutput({vecs[i].name, ".pulses"}, pulse_cnt, vecs[i].exp_pulses);
            checkOutput({vecs[i].name, ".seen_lock"}, int'(seen_lock), vecs[i].exp_seen);
        end

        // Clear while locked with ten errors; the sample during clear is discarded
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, fired);
        runSamples(192, 0, 0, 1'b0, 1'b0);
        checkOutput("pre_clear.locked", int'(locked_o), 1);
        runSamples(64, 0, 10, 1'b0, 1'b0);
        checkAll("pre_clear", 1, 5, 64, 10, 0, 0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, fired);
        checkAll("clear", 0, 0, 0, 0, 0, 0);
        runSamples(191, 0, 0, 1'b0, 1'b0);
        checkOutput("clear_s191.locked", int'(locked_o), 0);
        runSamples(1, 0, 0, 1'b0, 1'b0);
        checkAll("clear_s192", 1, 5, 0, 0, 0, 0);

        // Asynchronous reset between clock edges
        runSamples(20, 0, 3, 1'b0, 1'b0);
        checkAll("pre_rst", 1, 5, 20, 3, 0, 0);
        #3 rst = 1'b0;
        #1;
        checkAll("async_rst", 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        checkAll("rst_held", 0, 0, 0, 0, 0, 0);
        rst = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule

// File: doc/ber_checker.md
Name: ber_checker

Overview:
- Receive-end bit-error-rate monitor for the convolutional encoder/decoder chain. It is the reader/checker for the channel error injector.
- Captures the original bits entering the encoder (reference stream) and the bits leaving the decoder.
- Finds the decoder latency automatically, then locks and counts decoded bits and bit errors.
- Drops lock and re-searches if the error density becomes excessive.

Parameters:
- MAX_LAT, 64: depth of the reference history; candidate latencies are 0..MAX_LAT-1 (power of 2).
- SYNC_WIN, 32: decoded samples evaluated per candidate latency during search.
- SYNC_ERR_MAX, 2: maximum mismatches in one SYNC_WIN for a candidate to be accepted.
- LOSS_WIN, 64: decoded samples per loss-of-lock evaluation block while locked.
- LOSS_ERR, 16: errors in a LOSS_WIN block strictly above this value cause loss of lock.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous active-low reset.
- ref_bit_i, input, 1: bit presented to the encoder.
- ref_valid_i, input, 1: ref_bit_i is valid this cycle; equals the encoder enable.
- dec_bit_i, input, 1: decoder output bit.
- dec_valid_i, input, 1: dec_bit_i is valid this cycle.
- clear_i, input, 1: synchronous clear of the statistics counters and the state machine.
- locked_o, output, 1: latency found; statistics are accumulating.
- lat_o, output, $clog2(MAX_LAT): current candidate latency (SEARCH) or locked latency (LOCKED).
- bit_cnt_o, output, CNT_W: decoded samples compared while locked.
- err_cnt_o, output, CNT_W: mismatches while locked.
- resync_cnt_o, output, 8: number of loss-of-lock events.
- err_pulse_o, output, 1: one-cycle pulse for each locked-state mismatch.

Behaviour:
- Reset (rst low, asynchronous):
  - History = 0; state = SEARCH; lat = 0; window counters = 0.
  - All outputs 0: locked_o, lat_o, bit_cnt_o, err_cnt_o, resync_cnt_o, err_pulse_o.
- History:
  - MAX_LAT-bit shift register; hist[0] is the newest bit.
  - On ref_valid_i: hist <= {hist[MAX_LAT-2:0], ref_bit_i}.
  - Comparison uses the registered, pre-shift history.
  - Latency k therefore means dec_bit_i is compared with the reference bit accepted k+1 ref-valid events earlier.
  - Simultaneous ref_valid_i and dec_valid_i is legal; the compare uses the old history.
- Mismatch: mis = dec_bit_i ^ hist[lat]. It is evaluated only when dec_valid_i = 1.
- State SEARCH:
  - win_cnt and win_err are tracked per candidate.
  - On each dec_valid_i: win_cnt++ and win_err += mis; win_err saturates at SYNC_ERR_MAX+1.
  - When win_cnt reaches SYNC_WIN (its last sample included):
    - If win_err <= SYNC_ERR_MAX: go to LOCKED, keep lat, set locked_o on the next edge.
    - Otherwise lat <= lat+1, wrapping from MAX_LAT-1 to 0.
    - In both cases win_cnt and win_err clear.
  - Counters bit_cnt_o and err_cnt_o hold their values in SEARCH.
- State LOCKED:
  - On each dec_valid_i: bit_cnt++ and err_cnt += mis; both saturate at 2^CNT_W-1.
  - err_pulse_o is registered: high the cycle after a mismatch.
  - Loss-of-lock tracking uses blk_cnt and blk_err.
  - When blk_cnt reaches LOSS_WIN, the block is evaluated. If blk_err > LOSS_ERR:
    - Go to SEARCH; lat <= 0; locked_o <= 0.
    - resync_cnt++, saturating at 255.
    - bit_cnt and err_cnt hold their values.
  - Block counters clear at each block end.
- clear_i (synchronous, highest priority after reset):
  - bit_cnt, err_cnt, resync_cnt, and window/block counters <= 0.
  - state <= SEARCH; lat <= 0; locked_o <= 0.
  - History is not cleared.
  - A dec_valid_i sample in the same cycle is discarded.
- Latency: a comparison result reaches the counters and err_pulse_o one clock after the dec_valid_i cycle.
- No backpressure: the inputs are streaming and the block always accepts.
- History contents before MAX_LAT ref samples have been accepted are the reset zeros; the search may reject early candidates for this reason, which is acceptable.
- Reset mid-operation: immediate return to the reset state; no partial statistics are retained.

Test Plan:
- PRBS-7 reference with ref_valid_i = 1 every cycle; decoded stream = reference delayed exactly 6 ref events, error-free (lat 5 by the definition above) -> lat_o steps 0..5; locked_o rises after 6*32 = 192 dec samples (+1 cycle); lat_o = 5; err_cnt_o = 0.
- Locked as above, then invert every 8th decoded bit for 256 samples -> bit_cnt_o = 256, err_cnt_o = 32, eight err_pulse_o pulses per 64 samples, locked_o stays 1, resync_cnt_o = 0.
- Locked, then invert every 2nd decoded bit -> 32 errors in the first 64-sample block > 16; locked_o falls; resync_cnt_o = 1; lat_o = 0; search re-locks at lat 5 once errors stop.
- Decoded stream = independent PRBS (uncorrelated) for 3*64*32 samples -> never locks; lat_o wraps 63 -> 0 each pass; counters remain 0.
- Assert clear_i while locked with err_cnt_o = 10 -> next cycle: counters 0, locked_o = 0, lat_o = 0, search restarts; pulse rst low mid-window -> all outputs 0 asynchronously.
- ref_valid_i and dec_valid_i gated at 50% duty (same pattern, delayed) with simultaneous events -> still locks at the same latency in ref-event units; bit_cnt_o counts only valid samples.
